gate_seq_ctrl: RTL and testbench

Sequencing controller for the 3-input delay-gate datapath. On a start request it drives the gate's `a`, `b`, `c` inputs through all eight input vectors and holds each vector for a programmable settle window. At the end of each window it samples the gate output `y` and builds an 8-bit truth table, which it compares against an expected table. It replaces hand-written `initial` stimulus with a clocked, repeatable sweep, and sits between the bench or top level and the gate instance.

---
 rtl/gate_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_gate_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_seq_ctrl.sv
// ---------------------------------------------------------------------------
// gate_seq_ctrl
// Sweeps the 3-input delay gate through all eight input vectors, holding
// each one for SETTLE cycles, samples the gate output at the end of every
// window and builds an 8-bit truth table that is compared with an expected
// table latched at start.
//
// Parameters
//   SETTLE   cycles each vector is held before y_in is sampled (1..255)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   run request, accepted in IDLE or DONE
//   exp_tt   in   expected truth table, latched on accepted start
//   y_in     in   output of the gate under test
//   a,b,c    out  registered gate inputs, vector index {a,b,c} (c = LSB)
//   busy     out  sweep in progress
//   done     out  one-cycle pulse when the sweep completes
//   truth    out  sampled truth table, truth[i] = y for vector i
//   match    out  truth == latched exp_tt, valid from done to next start
//   glitch   out  glitch[i]: y toggled inside the window of vector i
//
// Build option
//   GATE_SEQ_GLITCH_CHECK_EN  when defined, y_in is tracked every RUN cycle
//                             and in-window toggles set sticky glitch bits;
//                             otherwise glitch is tied to 8'h00.
//
// States
//   state | meaning
//   IDLE  | waiting for start, results held
//   RUN   | sweeping vectors 0..7
//   DONE  | one-cycle completion pulse, may re-accept start
// ---------------------------------------------------------------------------
module gate_seq_ctrl #(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] exp_tt,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth,
    output logic       match,
    output logic [7:0] glitch
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

    logic [1:0] r_state;
    logic [2:0] r_vec;
    logic [7:0] r_cnt;
    logic [7:0] r_exp;
    logic [7:0] r_truth;
    logic       r_match;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;

    logic       w_accept;
    logic       w_last;
    logic [7:0] w_truth_nxt;

    // start is honoured everywhere except during the sweep itself
    assign w_accept = start && (r_state != ST_RUN);
    assign w_last   = (r_cnt == 8'd0);

    // truth table including this cycle's sample, so match can be resolved
    // on the same edge that enters DONE
    always_comb begin
        w_truth_nxt = r_truth;
        if (r_state == ST_RUN && w_last) begin
            w_truth_nxt[r_vec] = y_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= 3'd0;
            r_cnt   <= 8'd0;
            r_exp   <= 8'h00;
            r_truth <= 8'h00;
            r_match <= 1'b0;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_accept) begin
            r_state <= ST_RUN;
            r_exp   <= exp_tt;
            r_truth <= 8'h00;
            r_match <= 1'b0;
            r_vec   <= 3'd0;
            r_cnt   <= CNT_LOAD;
            r_abc   <= 3'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_truth <= w_truth_nxt;
                    if (!w_last) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_vec == 3'd7) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_abc   <= 3'd0;
                        r_match <= (w_truth_nxt == r_exp);
                    end else begin
                        r_vec <= r_vec + 3'd1;
                        r_abc <= r_vec + 3'd1;
                        r_cnt <= CNT_LOAD;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_SEQ_GLITCH_CHECK_EN
    logic       r_y_prev;
    logic [7:0] r_glitch;

    // The first cycle of a window (counter still at its load value) is
    // never compared: the vector just changed, so a transition is expected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_prev <= 1'b0;
            r_glitch <= 8'h00;
        end else if (w_accept) begin
            r_glitch <= 8'h00;
        end else if (r_state == ST_RUN) begin
            r_y_prev <= y_in;
            if (r_cnt != CNT_LOAD && y_in != r_y_prev) begin
                r_glitch[r_vec] <= 1'b1;
            end
        end
    end

    assign glitch = r_glitch;
`else
    assign glitch = 8'h00;
`endif

    assign {a, b, c} = r_abc;
    assign busy      = r_busy;
    assign done      = r_done;
    assign truth     = r_truth;
    assign match     = r_match;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
module tb_gate_seq_ctrl;

    localparam int S = 4;

    typedef struct {
        int         done_e;
        logic [7:0] tt;
        logic       mt;
        logic [7:0] gl;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] exp_tt;
    logic       y_in;
    logic       a, b, c;
    logic       busy, done, match;
    logic [7:0] truth, glitch;

    // stimulus knobs for the next accepted sweep
    logic [7:0] d_gate;
    logic       d_inj_on;
    int         d_inj_v;
    int         d_inj_k;

    // reference model state
    int         ecnt;
    int         t0;
    bit         have;
    logic [7:0] m_gate;
    logic       m_inj_on;
    int         m_inj_e;
    logic       r_inj;
    sb_t        sb[$];

    // monitor state
    logic [7:0] l_truth, l_gl;
    logic       l_mt;
    int         n_cmp;
    int         n_err;

    gate_seq_ctrl #(.SETTLE(S)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .exp_tt (exp_tt),
        .y_in   (y_in),
        .a      (a),
        .b      (b),
        .c      (c),
        .busy   (busy),
        .done   (done),
        .truth  (truth),
        .match  (match),
        .glitch (glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the gate: a truth table indexed by the DUT's vector, plus an optional
    // one-cycle disturbance
    assign y_in = m_gate[{a, b, c}] ^ r_inj;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, ecnt, act, expv);
        end
    endtask

    // Reference model: accept rules and expected results at accept time.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have     = 1'b0;
            m_inj_on = 1'b0;
            sb.delete();
        end else begin
            ecnt++;
            if (start && !(have && ecnt >= t0 + 1 && ecnt <= t0 + 8 * S)) begin
                sb_t e;
                t0       = ecnt;
                have     = 1'b1;
                m_gate   = d_gate;
                m_inj_on = d_inj_on;
                m_inj_e  = t0 + d_inj_v * S + d_inj_k - 1;
                e.tt     = d_gate;
                e.gl     = 8'h00;
                if (d_inj_on) begin
                    // a pulse on the sampled cycle corrupts the truth bit;
                    // any pulse inside a multi-cycle window is a glitch
                    if (d_inj_k == S) e.tt[d_inj_v] = ~e.tt[d_inj_v];
`ifdef GATE_SEQ_GLITCH_CHECK_EN
                    if (S >= 2) e.gl[d_inj_v] = 1'b1;
`endif
                end
                e.mt     = (e.tt == exp_tt);
                e.done_e = t0 + 8 * S;
                sb.push_back(e);
            end
        end
    end

    // disturbance window is refreshed away from the sampling edge
    always @(negedge clk) begin
        r_inj = m_inj_on && have && (ecnt == m_inj_e);
    end

    // Monitor
    always @(negedge clk) begin
        bit exp_run, exp_done;
        if (!rst_n) begin
            chk("rst_abc", {a, b, c}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_truth", truth, 0);
            chk("rst_match", match, 0);
            chk("rst_glitch", glitch, 0);
            l_truth = 8'h00;
            l_gl    = 8'h00;
            l_mt    = 1'b0;
        end else begin
            exp_run  = have && ecnt >= t0 && ecnt <= t0 + 8 * S - 1;
            exp_done = have && ecnt == t0 + 8 * S;
            chk("busy", busy, int'(exp_run));
            chk("done", done, int'(exp_done));
            chk("abc", {a, b, c}, exp_run ? (ecnt - t0) / S : 0);
            if (exp_run && ecnt == t0) begin
                chk("clr_truth", truth, 0);
                chk("clr_match", match, 0);
                chk("clr_glitch", glitch, 0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("done_edge", ecnt, e.done_e);
                    chk("truth", truth, e.tt);
                    chk("match", match, e.mt);
                    chk("glitch", glitch, e.gl);
                    l_truth = e.tt;
                    l_mt    = e.mt;
                    l_gl    = e.gl;
                end
            end else if (!exp_run) begin
                chk("hold_truth", truth, l_truth);
                chk("hold_match", match, l_mt);
                chk("hold_glitch", glitch, l_gl);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rand_knobs();
        d_gate   = 8'($urandom);
        exp_tt   = ($urandom % 2 == 0) ? d_gate : 8'($urandom);
        d_inj_on = 1'($urandom % 2);
        d_inj_v  = int'($urandom_range(0, 7));
        d_inj_k  = int'($urandom_range(1, S));
    endtask

    task automatic set_knobs(input logic [7:0] g, input logic [7:0] ex);
        d_gate   = g;
        exp_tt   = ex;
        d_inj_on = 1'b0;
        d_inj_v  = 0;
        d_inj_k  = 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        ecnt     = 0;
        t0       = 0;
        have     = 1'b0;
        m_gate   = 8'h00;
        m_inj_on = 1'b0;
        m_inj_e  = 0;
        r_inj    = 1'b0;
        l_truth  = 8'h00;
        l_gl     = 8'h00;
        l_mt     = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        set_knobs(8'hEA, 8'hEA);

        // reset then idle
        tick(3);
        rst_n = 1'b1;
        tick(20);

        // y = (a&b)|c, matching and mismatching expectation
        set_knobs(8'hEA, 8'hEA);
        pulse_start();
        tick(8 * S + 4);
        set_knobs(8'hEA, 8'hE8);
        pulse_start();
        tick(8 * S + 4);

        // start pulse during vector 3 is ignored
        set_knobs(8'hEA, 8'hEA);
        pulse_start();
        tick(3 * S - 1);
        pulse_start();
        tick(5 * S + 4);

        // start held: back-to-back sweeps with knobs changing every cycle
        start = 1'b1;
        repeat (3 * (8 * S + 1) + 2) begin
            rand_knobs();
            tick(1);
        end
        start = 1'b0;
        tick(8 * S + 4);

        // reset during vector 5, then a clean sweep
        set_knobs(8'hEA, 8'hEA);
        pulse_start();
        tick(5 * S + 1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        pulse_start();
        tick(8 * S + 4);

        // one-cycle disturbance in the middle of vector 2's window
        set_knobs(8'hEA, 8'hEA);
        d_inj_on = 1'b1;
        d_inj_v  = 2;
        d_inj_k  = (S >= 3) ? 3 : 1;
        pulse_start();
        tick(8 * S + 4);

        // random traffic with occasional resets
        repeat (1500) begin
            rand_knobs();
            start = ($urandom % 8 == 0);
            rst_n = ($urandom % 300 != 0);
            tick(1);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick(8 * S + 6);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
